// File: rtl/ft_host_cmd_tx_pkg.sv
// Shared constants and types for the FT245 host-side command and response transmitters.
package ft_host_cmd_tx_pkg;

    localparam logic [7:0] ID_BYTE      = 8'hCD;
    localparam logic [7:0] RESP_ID_BYTE = 8'hDC;

    localparam logic [3:0] CMD_PING  = 4'h0;
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_READ  = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_ID   = 3'd1,
        ST_SEND_CMD  = 3'd2,
        ST_SEND_ADDR = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_SEND_DATA = 3'd5
    } tx_state_t;

    function automatic logic cmd_legal(input logic [3:0] code);
        return (code == CMD_PING) || (code == CMD_WRITE) || (code == CMD_READ);
    endfunction

endpackage

// File: rtl/ft_host_cmd_tx_dword_serializer.sv
// Splits a 32-bit word into four bytes MSB-first, advancing one byte per cycle the FIFO has room.
module ft_dword_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        active,
    input  logic        full,
    output logic        issue,
    output logic [7:0]  byte_out,
    output logic        last_byte
);

    logic [31:0] shift_reg;
    logic [1:0]  byte_cnt_reg;

    assign issue     = active && !full;
    assign byte_out  = shift_reg[31:24];
    assign last_byte = (byte_cnt_reg == 2'd3);

    // A load takes priority so the next dword can start on the same edge the last byte leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg    <= '0;
            byte_cnt_reg <= '0;
        end else if (load) begin
            shift_reg    <= load_word;
            byte_cnt_reg <= '0;
        end else if (issue) begin
            shift_reg    <= {shift_reg[23:0], 8'h00};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

endmodule

// File: rtl/ft_host_cmd_tx.sv
// Host-side command packet transmitter: ID byte, command dword, optional address and write-data dwords.
module ft_host_cmd_tx
    import ft_host_cmd_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_en,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_command,
    input  logic [31:0] cmd_address,
    input  logic [23:0] cmd_data_count,
    output logic        data_ready,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic        out_fifo_wr,
    output logic [7:0]  out_fifo_data,
    input  logic        out_fifo_full
);

    tx_state_t   state;
    logic [7:0]  command_reg;
    logic [23:0] count_reg;
    logic [31:0] address_reg;
    logic [23:0] words_left_reg;

    logic        cmd_ready_reg, data_ready_reg, cmd_done_reg, cmd_error_reg, wr_reg;
    logic [7:0]  data_reg;

    logic        dword_state, ser_issue, ser_last, ser_load;
    logic [31:0] ser_word;
    logic [7:0]  ser_byte;

    assign cmd_ready     = cmd_ready_reg;
    assign data_ready    = data_ready_reg;
    assign cmd_done      = cmd_done_reg;
    assign cmd_error     = cmd_error_reg;
    assign out_fifo_wr   = wr_reg;
    assign out_fifo_data = data_reg;

    assign dword_state = (state == ST_SEND_CMD) || (state == ST_SEND_ADDR) || (state == ST_SEND_DATA);

    always_comb begin
        ser_load = 1'b0;
        ser_word = data_in;
        case (state)
            ST_SEND_ID: begin
                ser_load = !out_fifo_full;
                ser_word = {command_reg, count_reg};
            end
            ST_SEND_CMD: begin
                ser_load = ser_issue && ser_last;
                ser_word = address_reg;
            end
            ST_WAIT_DATA: ser_load = data_valid;
            default: ser_load = 1'b0;
        endcase
    end

    ft_dword_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_word (ser_word),
        .active    (dword_state),
        .full      (out_fifo_full),
        .issue     (ser_issue),
        .byte_out  (ser_byte),
        .last_byte (ser_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            command_reg    <= '0;
            count_reg      <= '0;
            address_reg    <= '0;
            words_left_reg <= '0;
            cmd_ready_reg  <= 1'b0;
            data_ready_reg <= 1'b0;
            cmd_done_reg   <= 1'b0;
            cmd_error_reg  <= 1'b0;
            wr_reg         <= 1'b0;
            data_reg       <= '0;
        end else begin
            wr_reg        <= 1'b0;
            cmd_done_reg  <= 1'b0;
            cmd_error_reg <= 1'b0;
            if (dword_state && ser_issue) begin
                wr_reg   <= 1'b1;
                data_reg <= ser_byte;
            end
            case (state)
                ST_IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_en && cmd_ready_reg) begin
                        command_reg    <= cmd_command;
                        count_reg      <= cmd_data_count;
                        address_reg    <= cmd_address;
                        words_left_reg <= (cmd_data_count == 24'd0) ? 24'd0 : cmd_data_count - 24'd1;
                        if (cmd_legal(cmd_command[3:0])) begin
                            cmd_ready_reg <= 1'b0;
                            state         <= ST_SEND_ID;
                        end else begin
                            cmd_error_reg <= 1'b1;
                        end
                    end
                end
                ST_SEND_ID: begin
                    if (!out_fifo_full) begin
                        wr_reg   <= 1'b1;
                        data_reg <= ID_BYTE;
                        state    <= ST_SEND_CMD;
                    end
                end
                ST_SEND_CMD: begin
                    if (ser_issue && ser_last) begin
                        if (command_reg[3:0] == CMD_PING) begin
                            state         <= ST_IDLE;
                            cmd_done_reg  <= 1'b1;
                            cmd_ready_reg <= 1'b1;
                        end else begin
                            state <= ST_SEND_ADDR;
                        end
                    end
                end
                ST_SEND_ADDR: begin
                    if (ser_issue && ser_last) begin
                        if (command_reg[3:0] == CMD_READ) begin
                            state         <= ST_IDLE;
                            cmd_done_reg  <= 1'b1;
                            cmd_ready_reg <= 1'b1;
                        end else begin
                            state          <= ST_WAIT_DATA;
                            data_ready_reg <= 1'b1;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_valid) begin
                        data_ready_reg <= 1'b0;
                        state          <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (ser_issue && ser_last) begin
                        if (words_left_reg == 24'd0) begin
                            state         <= ST_IDLE;
                            cmd_done_reg  <= 1'b1;
                            cmd_ready_reg <= 1'b1;
                        end else begin
                            words_left_reg <= words_left_reg - 24'd1;
                            state          <= ST_WAIT_DATA;
                            data_ready_reg <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
